// File: rtl/multu_sequencer.sv
// Multi-cycle unsigned multiplier with architectural HI/LO registers.
// Radix-2 shift-add over WIDTH steps; stalls the core on dependent commands.
module multu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNTW-1:0]  count_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH:0]   sum_s;
  logic             last_step_s;
  logic             accept_s;

  // One shift-add step; the carry lands in hi's MSB on the next shift.
  always_comb begin
    sum_s       = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    last_step_s = (count_r == CNTW'(WIDTH - 1));
    accept_s    = start && (state_r != RUN);
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_step_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch and shift-add datapath; HI/LO hold whenever not running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CNTW{1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      count_r <= {CNTW{1'b0}};
      mcand_r <= srca;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= srcb;
    end else if (state_r == RUN) begin
      count_r      <= count_r + CNTW'(1);
      {hi_r, lo_r} <= {sum_s, lo_r[WIDTH-1:1]};
    end else begin
      count_r <= count_r;
      mcand_r <= mcand_r;
      hi_r    <= hi_r;
      lo_r    <= lo_r;
    end
  end

  // Stall is combinational so a dependent command is held in the same cycle.
  assign busy  = (state_r == RUN);
  assign done  = (state_r == DONE);
  assign stall = busy & (start | rd_hi | rd_lo);
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule

// File: doc/multu_sequencer.md
Name: multu_sequencer

Overview:
- Multi-cycle unsigned multiply unit with architectural HI/LO registers. It replaces the single-cycle multu path of the MIPS core.
- On a multu issue it runs an iterative radix-2 shift-add multiply over WIDTH cycles, then holds the 2*WIDTH-bit product in HI/LO.
- It drives a stall to the core when a multu, mfhi or mflo arrives while a multiply is in flight.
- Sits beside the ALU in the datapath. The decoder supplies issue/read strobes; the core's register-file write mux consumes hi/lo.

Parameters:
WIDTH  32  operand width; HI and LO are each WIDTH bits
CNTW   6   counter width; must satisfy 2^CNTW > WIDTH

Ports:
clk      in   1      clock, rising edge
reset    in   1      asynchronous, active-low reset
start    in   1      multu issued this cycle (decoder strobe)
srca     in   WIDTH  multiplicand (rs value)
srcb     in   WIDTH  multiplier (rt value)
rd_hi    in   1      mfhi issued this cycle
rd_lo    in   1      mflo issued this cycle
stall    out  1      core must hold PC/IF/ID this cycle
busy     out  1      multiply in progress (state RUN)
done     out  1      one-cycle pulse: product just completed
hi       out  WIDTH  HI register
lo       out  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, hi=0, lo=0, mcand=0.
  - stall, busy and done are all 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Latch mcand<=srca, hi<=0, lo<=srcb, count<=0; go to RUN.
  - stall=0 in the accepting cycle.
- RUN, one step per edge:
  - sum[WIDTH:0] = {1'b0,hi} + (lo[0] ? {1'b0,mcand} : 0).
  - {hi,lo} <= {sum, lo[WIDTH-1:1]}, i.e. the WIDTH+1-bit sum concatenated with lo shifted right by one.
  - The carry bit is never lost.
  - count<=count+1. When count==WIDTH-1 the step executes and the next state is DONE.
- Latency: start accepted at edge E. Exactly WIDTH RUN steps occur, at edges E+1..E+WIDTH.
  - In the cycle after edge E+WIDTH: state=DONE, done=1, busy=0, and {hi,lo} = srca*srcb (full 2*WIDTH-bit unsigned product).
- DONE with start=0: go to IDLE. DONE is one cycle only; done=1 only in DONE.
- busy = (state==RUN).
- stall = busy & (start | rd_hi | rd_lo). Combinational, no registered delay.
- Commands issued during RUN:
  - start: the core holds the instruction, so start is re-presented every cycle. It is accepted in the first non-RUN cycle (DONE).
  - rd_hi/rd_lo: the core re-presents them until stall drops. In DONE/IDLE, hi/lo outputs are the final product, so the read sees the new result.
- Reading while not busy: hi/lo are stable; no stall.
- start with rd_hi/rd_lo in the same cycle: cannot occur from a single-issue core. Required result if it does: start is accepted, the read gets the pre-start (old) HI/LO.
- hi/lo hold their value in IDLE/DONE indefinitely. Only start or reset modifies them.
- Intermediate hi/lo during RUN are partial values. The core must not consume them; the stall guarantees this.
- Reset mid-RUN: immediate abort, all registers cleared to reset values, no done pulse.
- Operand changes on srca/srcb after acceptance have no effect, because operands are latched at acceptance.
- Arithmetic is unsigned only. There is no overflow, since the product always fits in 2*WIDTH bits.

Test Plan:
- Basic: start with srca=3, srcb=5. Required: busy for 32 cycles, done pulse, hi=0x00000000, lo=0x0000000F.
- Max: srca=0xFFFFFFFF, srcb=0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001; done exactly 32 cycles after the accepting edge.
- Read-during-run: start with 0x12345678 * 0x9ABCDEF0, then hold rd_hi=1 from the next cycle.
  - Required: stall=1 for every RUN cycle, dropping in DONE.
  - hi=0x0B00EA4E, lo=0x242D2080.
- Back-to-back: 7*6 followed by a second start held through RUN with srca=2, srcb=0x80000000.
  - Required: the second start is accepted in the DONE cycle; final hi=0x00000001, lo=0x00000000.
- Zero operand: srca=0, srcb=0xDEADBEEF. Required: the full 32-cycle latency is still observed; hi=lo=0.
- Reset mid-op: drive reset low at RUN step 10. Required: hi=lo=0, busy=stall=done=0 asynchronously. After release, state is IDLE and a fresh 4*4 gives lo=0x10.
